// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the word-serial arithmetic engines
package arith_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WORD_W = 32;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/rippleCarryAdder.sv
// rippleCarryAdder: 32-bit ripple-carry adder with carry-out and signed overflow
module rippleCarryAdder
    import arith_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              overflow
);
    logic carry;
    logic carry_msb;
    always_comb begin
        carry = cin;
        carry_msb = 1'b0;
        sum = '0;
        for (int i = 0; i < WORD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            if (i == WORD_W - 1) carry_msb = carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end
    assign cout = carry;
    // Signed overflow: carry into the sign bit differs from carry out of it
    assign overflow = carry ^ carry_msb;
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WORDS x 32-bit add/subtract, one word per cycle LSW first
module wide_add_sequencer
    import arith_pkg::*;
#(
    parameter  int WORDS  = 4,
    localparam int DATA_W = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_overflow,
    output logic              out_zero,
    output logic              busy
);
    localparam int CNT_W = WORDS > 1 ? $clog2(WORDS) : 1;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              carry;
    logic [DATA_W-1:0] a_q, b_q, sum_next;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout, add_ovf, last, accept;

    rippleCarryAdder u_add (
        .a        (a_q[cnt*WORD_W +: WORD_W]),
        .b        (b_q[cnt*WORD_W +: WORD_W]),
        .cin      (carry),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == CNT_W'(WORDS - 1);

    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid) state_n = RUN;
        if (state == RUN && last) state_n = DONE;
        if (state == DONE && out_ready) state_n = IDLE;
    end

    // Result with the current word merged in, so the zero flag sees every word
    always_comb begin
        sum_next = out_sum;
        sum_next[cnt*WORD_W +: WORD_W] = add_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            carry        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            out_sum      <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_op == OP_SUB ? ~in_b : in_b;
                carry <= in_op;
                cnt   <= '0;
            end else if (state == RUN) begin
                out_sum <= sum_next;
                carry   <= add_cout;
                cnt     <= cnt + 1'b1;
                if (last) begin
                    out_cout     <= add_cout;
                    out_overflow <= add_ovf;
                    out_zero     <= sum_next == '0;
                end
            end
        end
    end
endmodule
